// File: rtl/uart_loopback_fifo_if.sv
// System-side signals of uart_loopback_fifo: mode/clear controls in, RX status and FIFO level out.
interface uart_loopback_fifo_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic              mode_i;
  logic              clr_i;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              frame_err_o;
  logic              overrun_o;
  logic [AW:0]       fifo_level_o;

  modport master (
    output mode_i, clr_i,
    input  rx_data_o, rx_valid_o, frame_err_o, overrun_o, fifo_level_o
  );

  modport slave (
    input  mode_i, clr_i,
    output rx_data_o, rx_valid_o, frame_err_o, overrun_o, fifo_level_o
  );
endinterface

// File: rtl/uart_loopback_fifo.sv
// UART loopback: RX -> FIFO -> TX echo (mode 0) or incrementing-pattern generator on TX (mode 1).
module uart_loopback_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BIT_RATE   = 9600,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned GEN_MAX    = (1 << DATA_W) - 1
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 rx_i,
  output logic                 tx_o,
  uart_loopback_fifo_if.slave  sys
);
  localparam int unsigned CPB   = CLK_HZ / BIT_RATE;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(CPB / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [AW:0]       DEPTH_L   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] GEN_LAST  = DATA_W'(GEN_MAX);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // ---------------- receiver ----------------
  rx_state_e         rx_state_q;
  logic              rx_meta_q, rxs_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [BIT_W-1:0]  rx_bit_q;
  logic [DATA_W-1:0] rx_shift_q, rx_data_q;
  logic              rx_valid_q, frame_err_q;
  logic              rx_tick, push;

  assign rx_tick = (rx_cnt_q == CNT_LAST);
  assign push    = (rx_state_q == RX_STOP) && rx_tick && rxs_q;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rxs_q       <= rx_meta_q;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (!rxs_q) begin
          rx_state_q <= RX_START;
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
        end
        RX_START: if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_q   <= '0;
          rx_state_q <= rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_DATA: if (rx_tick) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {rxs_q, rx_shift_q[DATA_W-1:1]};
          rx_bit_q   <= rx_bit_q + 1'b1;
          if (rx_bit_q == BIT_LAST) rx_state_q <= RX_STOP;
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_STOP: if (rx_tick) begin
          rx_cnt_q <= '0;
          if (rxs_q) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= rx_shift_q;
            rx_state_q <= RX_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            rx_state_q  <= RX_BREAK;
          end
        end else begin
          rx_cnt_q <= rx_cnt_q + 1'b1;
        end
        RX_BREAK: if (rxs_q) rx_state_q <= RX_IDLE;
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              overrun_q, overrun_d;
  logic              full, pop, wr_en;
  tx_state_e         tx_state_q;

  assign full  = (level_q == DEPTH_L);
  // A pop is only ever requested from a non-empty FIFO, so a full push is safe when it pairs with a pop.
  assign pop   = (tx_state_q == TX_IDLE) && !sys.mode_i && (level_q != '0) && !sys.clr_i;
  assign wr_en = push && (!full || pop) && !sys.clr_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    if (sys.clr_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && full && !pop) overrun_d = 1'b1;
      case ({wr_en, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------- transmitter ----------------
  logic [CNT_W-1:0]  tx_cnt_q;
  logic [BIT_W-1:0]  tx_bit_q;
  logic [DATA_W-1:0] tx_shift_q, gen_q;
  logic              tx_q, gen_frame_q, tx_tick;

  assign tx_tick = (tx_cnt_q == CNT_LAST);

  // tx_q is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_q        <= 1'b1;
      gen_q       <= '0;
      gen_frame_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (sys.mode_i) begin
            tx_shift_q  <= gen_q;
            gen_frame_q <= 1'b1;
            tx_cnt_q    <= '0;
            tx_state_q  <= TX_START;
          end else if (pop) begin
            tx_shift_q  <= mem_q[rd_ptr_q];
            gen_frame_q <= 1'b0;
            tx_cnt_q    <= '0;
            tx_state_q  <= TX_START;
          end
        end
        TX_START: begin
          tx_q <= 1'b0;
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          tx_q <= tx_shift_q[0];
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 1'b1;
            if (tx_bit_q == BIT_LAST) tx_state_q <= TX_STOP;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          tx_q <= 1'b1;
          if (tx_tick) begin
            tx_cnt_q   <= '0;
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase

      if (sys.clr_i)
        gen_q <= '0;
      else if ((tx_state_q == TX_STOP) && tx_tick && gen_frame_q)
        gen_q <= (gen_q == GEN_LAST) ? '0 : gen_q + 1'b1;
    end
  end

  assign tx_o             = tx_q;
  assign sys.rx_data_o    = rx_data_q;
  assign sys.rx_valid_o   = rx_valid_q;
  assign sys.frame_err_o  = frame_err_q;
  assign sys.overrun_o    = overrun_q;
  assign sys.fifo_level_o = level_q;
endmodule

// File: tb/tb_uart_loopback_fifo.sv
// Scoreboard bench for uart_loopback_fifo: 10 clocks/bit, 8 data bits, 4-deep FIFO, GEN_MAX=2.
module tb_uart_loopback_fifo;
  logic clk_i    = 1'b0;
  logic nreset_i = 1'b0;
  logic rx_i     = 1'b1;
  logic tx_o;

  uart_loopback_fifo_if #(.DATA_W(8), .FIFO_DEPTH(4)) sys_if ();

  uart_loopback_fifo #(
    .CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_W(8), .FIFO_DEPTH(4), .GEN_MAX(2)
  ) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .rx_i(rx_i), .tx_o(tx_o), .sys(sys_if)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    bit         chk_lat;
  } tx_item_t;

  logic [7:0] rx_exp_q [$];
  tx_item_t   tx_exp_q [$];

  int fe_cnt    = 0;
  int last_push = 0;
  bit gen_phase = 0;
  int gen_exp   = 0;
  int gen_prev  = 0;
  int gen_frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit good);
    rx_i = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      tick(10);
    end
    if (!good) begin
      rx_i = 1'b0;
      tick(30);
    end
    rx_i = 1'b1;
    tick(10);
  endtask

  // RX monitor: every rx_valid pulse pops the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_i);
      if (nreset_i && sys_if.rx_valid_o === 1'b1) begin
        last_push = cyc;
        if (rx_exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got word %0h expected none", sys_if.rx_data_o);
        end else begin
          e = rx_exp_q.pop_front();
          check("rx_data", sys_if.rx_data_o, e);
        end
      end
      if (nreset_i && sys_if.frame_err_o === 1'b1) fe_cnt++;
    end
  end

  // TX monitor: decodes frames at bit centres and checks against the queue or the generator model.
  initial begin
    bit         busy = 0;
    int         k = 0;
    int         start = 0;
    int         lat = 0;
    logic [7:0] data;
    tx_item_t   it;
    forever begin
      @(negedge clk_i);
      if (!nreset_i) begin
        busy = 0;
      end else if (!busy) begin
        if (tx_o === 1'b0) begin
          busy  = 1;
          k     = 0;
          start = cyc;
          lat   = cyc - last_push;
          data  = '0;
        end
      end else begin
        k++;
        if (k == 5) begin
          check("tx_start_bit", tx_o, 0);
        end else if (k >= 15 && k <= 85 && (k % 10) == 5) begin
          data[(k - 15) / 10] = tx_o;
        end else if (k == 95) begin
          busy = 0;
          check("tx_stop_bit", tx_o, 1);
          if (gen_phase) begin
            check("gen_value", data, gen_exp);
            gen_exp = (gen_exp == 2) ? 0 : gen_exp + 1;
            if (gen_frames > 0) check("gen_frame_period", start - gen_prev, 101);
            gen_prev = start;
            gen_frames++;
          end else if (tx_exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got frame %0h expected none", data);
          end else begin
            it = tx_exp_q.pop_front();
            check("tx_data", data, it.d);
            if (it.chk_lat) check("echo_latency", lat, 2);
          end
        end
      end
    end
  end

  initial begin
    int fe_base;
    bit saw_low;
    sys_if.mode_i = 1'b0;
    sys_if.clr_i  = 1'b0;

    // reset values
    #12;
    check("rst_tx", tx_o, 1);
    check("rst_rx_valid", sys_if.rx_valid_o, 0);
    check("rst_frame_err", sys_if.frame_err_o, 0);
    check("rst_overrun", sys_if.overrun_o, 0);
    check("rst_level", sys_if.fifo_level_o, 0);
    check("rst_rx_data", sys_if.rx_data_o, 0);
    tick(2);
    nreset_i = 1'b1;
    tick(5);

    // echo
    rx_exp_q.push_back(8'hA5);
    tx_exp_q.push_back('{d: 8'hA5, chk_lat: 1'b1});
    send(8'hA5, 1'b1);
    tick(120);
    check("echo_level_drained", sys_if.fifo_level_o, 0);

    // framing error, then a good frame
    fe_base = fe_cnt;
    send(8'h3C, 1'b0);
    tick(20);
    check("frame_err_count", fe_cnt - fe_base, 1);
    check("frame_err_no_push", sys_if.fifo_level_o, 0);
    rx_exp_q.push_back(8'h11);
    tx_exp_q.push_back('{d: 8'h11, chk_lat: 1'b1});
    send(8'h11, 1'b1);
    tick(120);

    // false start glitch
    fe_base = fe_cnt;
    saw_low = 0;
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) saw_low = 1;
    end
    check("false_start_tx_high", saw_low, 0);
    check("false_start_level", sys_if.fifo_level_o, 0);
    check("false_start_no_ferr", fe_cnt - fe_base, 0);
    tick(1);

    // asynchronous reset while TX is sending data bit 0 of 0x5A
    rx_exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    tick(15);
    check("pre_reset_tx_low", tx_o, 0);
    nreset_i = 1'b0;
    #1;
    check("reset_tx_high", tx_o, 1);
    check("reset_level", sys_if.fifo_level_o, 0);
    check("reset_rx_data", sys_if.rx_data_o, 0);
    tick(3);
    nreset_i = 1'b1;
    tick(5);
    rx_exp_q.push_back(8'h22);
    tx_exp_q.push_back('{d: 8'h22, chk_lat: 1'b1});
    send(8'h22, 1'b1);
    tick(120);

    // generator wrap with RX filling the FIFO until it overruns
    gen_exp    = 0;
    gen_frames = 0;
    gen_phase  = 1;
    sys_if.mode_i = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      rx_exp_q.push_back(8'(w));
      send(8'(w), 1'b1);
      tick(3);
      check($sformatf("level_after_word%0d", w), sys_if.fifo_level_o, (w < 4) ? w : 4);
      check($sformatf("overrun_after_word%0d", w), sys_if.overrun_o, (w == 5) ? 1 : 0);
    end
    sys_if.clr_i = 1'b1;
    tick(1);
    sys_if.clr_i  = 1'b0;
    sys_if.mode_i = 1'b0;
    check("clr_level", sys_if.fifo_level_o, 0);
    check("clr_overrun", sys_if.overrun_o, 0);
    tick(130);
    gen_phase = 0;
    check("gen_frames_seen_ge4", (gen_frames >= 4) ? 1 : 0, 1);
    check("post_clr_level", sys_if.fifo_level_o, 0);

    tick(20);
    check("rx_scoreboard_empty", rx_exp_q.size(), 0);
    check("tx_scoreboard_empty", tx_exp_q.size(), 0);
    check("frame_err_total", fe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
